// File: rtl/fm_pkg.sv
// Shared types and defaults for the FM patch sequencer: state codes,
// default widths and waveform code constants.
package fm_pkg;

  typedef enum logic [2:0] {
    ST_HALTED   = 3'd0,
    ST_PLAY     = 3'd1,
    ST_SEL_WAVE = 3'd2,
    ST_SEL_DST  = 3'd3,
    ST_LOAD_WGT = 3'd4
  } fm_state_e;

  localparam int FM_NUM_OSC  = 4;
  localparam int FM_WAVE_W   = 2;
  localparam int FM_WEIGHT_W = 8;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_SAW    = 2'd2;
  localparam logic [1:0] WAVE_TRI    = 2'd3;

endpackage

// File: rtl/fm_patch_sequencer_if.sv
// Board-side bundle of the patch sequencer: button, selection inputs and
// the write strobes/data going to the oscillator and FM-matrix banks.
interface fm_patch_sequencer_if #(
  parameter int NUM_OSC  = 4,
  parameter int WAVE_W   = 2,
  parameter int WEIGHT_W = 8
);

  logic                Continue;
  logic [NUM_OSC-1:0]  osc_sel;
  logic [NUM_OSC-1:0]  src_sel;
  logic [WAVE_W-1:0]   wave_sel;
  logic [WEIGHT_W-1:0] weight_in;

  logic                run;
  logic [NUM_OSC-1:0]  wave_we;
  logic [WAVE_W-1:0]   wave_data;
  logic                weight_we;
  logic [NUM_OSC-1:0]  weight_dst;
  logic [NUM_OSC-1:0]  weight_src;
  logic [WEIGHT_W-1:0] weight_data;
  logic [2:0]          state_o;

  modport master (
    output Continue, osc_sel, src_sel, wave_sel, weight_in,
    input  run, wave_we, wave_data, weight_we, weight_dst, weight_src,
           weight_data, state_o
  );

  modport slave (
    input  Continue, osc_sel, src_sel, wave_sel, weight_in,
    output run, wave_we, wave_data, weight_we, weight_dst, weight_src,
           weight_data, state_o
  );

endinterface

// File: rtl/fm_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and
// registered one-cycle press/release pulses on the debounced level.
module fm_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw_i,
  output logic press_o,
  output logic release_o,
  output logic quiet_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          prev_q;
  logic          press_q;
  logic          release_q;
  logic [CW-1:0] cnt_q;

  // Synchroniser keeps sampling through reset so a button held across
  // reset is already visible when reset drops.
  always_ff @(posedge Clk) begin
    sync1_q <= raw_i;
    sync2_q <= sync1_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      level_q   <= 1'b0;
      prev_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      prev_q    <= level_q;
      press_q   <= level_q & ~prev_q;
      release_q <= ~level_q & prev_q;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign quiet_o   = ~level_q & ~sync2_q;

endmodule

// File: rtl/fm_patch_sequencer.sv
// Patch-load sequencer: one Continue button walks waveform load, FM routing
// selection and FM weight load, emitting single-cycle write strobes.
module fm_patch_sequencer
  import fm_pkg::*;
#(
  parameter int NUM_OSC         = FM_NUM_OSC,
  parameter int WAVE_W          = FM_WAVE_W,
  parameter int WEIGHT_W        = FM_WEIGHT_W,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  fm_patch_sequencer_if.slave  bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic press;
  logic release_ev;
  logic quiet;

  fm_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clk      (Clk),
    .Reset    (Reset),
    .raw_i    (bus.Continue),
    .press_o  (press),
    .release_o(release_ev),
    .quiet_o  (quiet)
  );

  fm_state_e           state_q;
  logic                run_q;
  logic [NUM_OSC-1:0]  wave_we_q;
  logic [WAVE_W-1:0]   wave_data_q;
  logic                weight_we_q;
  logic [NUM_OSC-1:0]  weight_dst_q;
  logic [NUM_OSC-1:0]  weight_src_q;
  logic [WEIGHT_W-1:0] weight_data_q;
  logic [NUM_OSC-1:0]  dst_q;
  logic [NUM_OSC-1:0]  src_q;
  logic [TW-1:0]       to_q;
  logic                expire;

  assign expire = (TIMEOUT_CYCLES != 0) && (to_q == TO_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_HALTED;
      run_q         <= 1'b0;
      wave_we_q     <= '0;
      wave_data_q   <= '0;
      weight_we_q   <= 1'b0;
      weight_dst_q  <= '0;
      weight_src_q  <= '0;
      weight_data_q <= '0;
      dst_q         <= '0;
      src_q         <= '0;
      to_q          <= '0;
    end else begin
      wave_we_q   <= '0;
      weight_we_q <= 1'b0;
      case (state_q)
        ST_HALTED: begin
          if (quiet) begin
            state_q <= ST_PLAY;
            run_q   <= 1'b1;
          end
        end
        ST_PLAY: begin
          run_q <= 1'b1;
          if (press) state_q <= ST_SEL_WAVE;
        end
        ST_SEL_WAVE: begin
          if (release_ev) begin
            state_q <= ST_SEL_DST;
            to_q    <= '0;
            if (bus.osc_sel != '0) begin
              wave_we_q   <= bus.osc_sel;
              wave_data_q <= bus.wave_sel;
            end
          end
        end
        ST_SEL_DST: begin
          // A press arriving on the expiry cycle takes priority over abort.
          if (press) begin
            state_q <= ST_LOAD_WGT;
            dst_q   <= bus.osc_sel;
            src_q   <= bus.src_sel;
          end else if (expire) begin
            state_q <= ST_PLAY;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        ST_LOAD_WGT: begin
          if (release_ev) begin
            state_q <= ST_PLAY;
            if ((dst_q != '0) && (src_q != '0)) begin
              weight_we_q   <= 1'b1;
              weight_dst_q  <= dst_q;
              weight_src_q  <= src_q;
              weight_data_q <= bus.weight_in;
            end
          end
        end
        default: begin
          state_q <= ST_HALTED;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.run         = run_q;
  assign bus.wave_we     = wave_we_q;
  assign bus.wave_data   = wave_data_q;
  assign bus.weight_we   = weight_we_q;
  assign bus.weight_dst  = weight_dst_q;
  assign bus.weight_src  = weight_src_q;
  assign bus.weight_data = weight_data_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_fm_patch_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized button/selection run compared every cycle to a window-based model.
module tb_fm_patch_sequencer;

  localparam int NOSC = 4;
  localparam int DB   = 4;
  localparam int TO   = 64;
  localparam int MAXC = 32768;

  localparam int S_HALTED = 0, S_PLAY = 1, S_WAVE = 2, S_DST = 3, S_LOAD = 4;

  logic clk;
  logic rst;

  fm_patch_sequencer_if #(.NUM_OSC(NOSC), .WAVE_W(2), .WEIGHT_W(8)) bus ();

  fm_patch_sequencer #(
    .NUM_OSC(NOSC), .WAVE_W(2), .WEIGHT_W(8),
    .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  bit   raw_h [MAXC];
  bit   rise_h[MAXC];
  bit   fall_h[MAXC];
  bit   rst_h [MAXC];
  int   cyc = 0;
  int   since_rst = 0;
  bit   m_valid = 0;
  bit   m_level = 0;
  int   m_state = S_HALTED;
  bit   m_run = 0;
  logic [3:0] m_wave_we = 0;
  logic [1:0] m_wave_data = 0;
  bit   m_weight_we = 0;
  logic [3:0] m_wdst = 0, m_wsrc = 0, m_dst_l = 0, m_src_l = 0;
  logic [7:0] m_wdata = 0;
  int   entry_t = 0;

  initial begin
    forever begin
      @(posedge clk);
      begin
        int  t;
        bit  lvl_before, all_diff, press, rel, quiet;
        t = cyc;
        raw_h[t]  = bus.Continue;
        rst_h[t]  = rst;
        rise_h[t] = 0;
        fall_h[t] = 0;
        if (rst) begin
          m_valid = 1; since_rst = 0; m_level = 0;
          m_state = S_HALTED; m_run = 0; m_wave_we = 0; m_wave_data = 0;
          m_weight_we = 0; m_wdst = 0; m_wsrc = 0; m_wdata = 0;
          m_dst_l = 0; m_src_l = 0;
        end else begin
          since_rst++;
          lvl_before = m_level;
          // Debounced level flips once the last DB synchronised samples all disagree with it.
          if (since_rst >= DB) begin
            all_diff = 1;
            for (int k = 0; k < DB; k++)
              if (t - 2 - k < 0 || raw_h[t-2-k] == m_level) all_diff = 0;
            if (all_diff) begin
              m_level = !m_level;
              if (m_level) rise_h[t] = 1; else fall_h[t] = 1;
            end
          end
          press = (t >= 2) && rise_h[t-2] && !rst_h[t-1];
          rel   = (t >= 2) && fall_h[t-2] && !rst_h[t-1];
          quiet = (t >= 2) && !lvl_before && !raw_h[t-2];
          m_wave_we = 0;
          m_weight_we = 0;
          case (m_state)
            S_HALTED: if (quiet) m_state = S_PLAY;
            S_PLAY:   if (press) m_state = S_WAVE;
            S_WAVE: if (rel) begin
              m_state = S_DST; entry_t = t;
              if (bus.osc_sel != 0) begin
                m_wave_we = bus.osc_sel; m_wave_data = bus.wave_sel;
              end
            end
            S_DST: begin
              if (press) begin
                m_state = S_LOAD; m_dst_l = bus.osc_sel; m_src_l = bus.src_sel;
              end else if (t - entry_t == TO) m_state = S_PLAY;
            end
            S_LOAD: if (rel) begin
              m_state = S_PLAY;
              if (m_dst_l != 0 && m_src_l != 0) begin
                m_weight_we = 1; m_wdst = m_dst_l; m_wsrc = m_src_l; m_wdata = bus.weight_in;
              end
            end
            default: m_state = S_HALTED;
          endcase
          m_run = (m_state != S_HALTED);
        end
        cyc++;
      end
    end
  end

  // Per-cycle comparison against the model, one line per write transaction.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("m_state", 32'(bus.state_o), 32'(m_state));
        chk("m_run", 32'(bus.run), 32'(m_run));
        chk("m_wave_we", 32'(bus.wave_we), 32'(m_wave_we));
        chk("m_wave_data", 32'(bus.wave_data), 32'(m_wave_data));
        chk("m_weight_we", 32'(bus.weight_we), 32'(m_weight_we));
        chk("m_weight_dst", 32'(bus.weight_dst), 32'(m_wdst));
        chk("m_weight_src", 32'(bus.weight_src), 32'(m_wsrc));
        chk("m_weight_data", 32'(bus.weight_data), 32'(m_wdata));
        if (bus.wave_we != 0)
          $display("wave write   we=%b data=%0d", bus.wave_we, bus.wave_data);
        if (bus.weight_we)
          $display("weight write dst=%b src=%b data=%02h", bus.weight_dst, bus.weight_src, bus.weight_data);
      end
    end
  end

  task automatic rand_inputs();
    bus.osc_sel   = 4'($urandom_range(0, 15));
    bus.src_sel   = 4'($urandom_range(0, 15));
    bus.wave_sel  = 2'($urandom_range(0, 3));
    bus.weight_in = 8'($urandom_range(0, 255));
  endtask

  task automatic btn(input int hi);
    bus.Continue = 1'b1;
    tick(hi);
    bus.Continue = 1'b0;
    tick(8);
  endtask

  initial begin
    rst = 1'b1;
    bus.Continue = 1'b0;
    bus.osc_sel = 0; bus.src_sel = 0; bus.wave_sel = 0; bus.weight_in = 0;
    tick(4);
    chk("reset_state", 32'(bus.state_o), 32'd0);
    chk("reset_run", 32'(bus.run), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("play_state", 32'(bus.state_o), 32'd1);
    chk("play_run", 32'(bus.run), 32'd1);
    chk("play_wave_we", 32'(bus.wave_we), 32'd0);
    tick(5);

    // Glitch shorter than the debounce window is ignored.
    bus.Continue = 1'b1; tick(3); bus.Continue = 1'b0; tick(15);
    chk("glitch_state", 32'(bus.state_o), 32'd1);

    // Full load.
    bus.osc_sel = 4'b0101; bus.wave_sel = 2'd2;
    bus.Continue = 1'b1;
    tick(7);
    chk("press_lat_early", 32'(bus.state_o), 32'd1);
    tick(1);
    chk("press_lat", 32'(bus.state_o), 32'd2);
    tick(2);
    bus.Continue = 1'b0;
    tick(8);
    chk("wave_we", 32'(bus.wave_we), 32'h5);
    chk("wave_data", 32'(bus.wave_data), 32'd2);
    chk("sel_dst", 32'(bus.state_o), 32'd3);
    tick(1);
    chk("wave_we_1cyc", 32'(bus.wave_we), 32'd0);
    bus.osc_sel = 4'b0010; bus.src_sel = 4'b1000;
    bus.Continue = 1'b1;
    tick(8);
    chk("load_wgt", 32'(bus.state_o), 32'd4);
    bus.osc_sel = 4'b1111; bus.src_sel = 4'b0001; bus.weight_in = 8'hA5;
    tick(2);
    bus.Continue = 1'b0;
    tick(8);
    chk("weight_we", 32'(bus.weight_we), 32'd1);
    chk("weight_dst", 32'(bus.weight_dst), 32'h2);
    chk("weight_src", 32'(bus.weight_src), 32'h8);
    chk("weight_data", 32'(bus.weight_data), 32'hA5);
    chk("back_play", 32'(bus.state_o), 32'd1);
    tick(1);
    chk("weight_we_1cyc", 32'(bus.weight_we), 32'd0);

    // Zero masks suppress writes but still advance.
    bus.osc_sel = 0; bus.src_sel = 0;
    btn(10);
    chk("zero_wave_we", 32'(bus.wave_we), 32'd0);
    chk("zero_wave_state", 32'(bus.state_o), 32'd3);
    bus.osc_sel = 4'b1111;
    btn(10);
    chk("zero_weight_we", 32'(bus.weight_we), 32'd0);
    chk("zero_weight_state", 32'(bus.state_o), 32'd1);
    chk("data_hold", 32'(bus.weight_data), 32'hA5);

    // Idle timeout.
    bus.osc_sel = 4'b0101;
    btn(10);
    tick(63);
    chk("timeout_pre", 32'(bus.state_o), 32'd3);
    tick(1);
    chk("timeout_play", 32'(bus.state_o), 32'd1);
    chk("timeout_no_we", 32'(bus.weight_we), 32'd0);

    // Press landing on the expiry cycle wins.
    btn(10);
    bus.osc_sel = 4'b0011; bus.src_sel = 4'b0100; bus.weight_in = 8'h3C;
    tick(56);
    bus.Continue = 1'b1;
    tick(8);
    chk("expiry_press", 32'(bus.state_o), 32'd4);
    tick(2);
    bus.Continue = 1'b0;
    tick(8);
    chk("expiry_weight_we", 32'(bus.weight_we), 32'd1);
    chk("expiry_weight_dst", 32'(bus.weight_dst), 32'h3);
    chk("expiry_weight_data", 32'(bus.weight_data), 32'h3C);

    // Reset during LOAD_WGT with the button held.
    btn(10);
    bus.Continue = 1'b1;
    tick(8);
    chk("pre_reset_load", 32'(bus.state_o), 32'd4);
    rst = 1'b1;
    tick(3);
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_run", 32'(bus.run), 32'd0);
    chk("rst_weight_we", 32'(bus.weight_we), 32'd0);
    rst = 1'b0;
    tick(30);
    chk("held_halted", 32'(bus.state_o), 32'd0);
    bus.Continue = 1'b0;
    tick(5);
    chk("release_halted", 32'(bus.state_o), 32'd0);
    tick(10);
    chk("release_play", 32'(bus.state_o), 32'd1);

    // Randomized bursts with occasional reset.
    for (int b = 0; b < 150; b++) begin
      int hi, lo;
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1; tick(3); rst = 1'b0;
      end
      hi = $urandom_range(1, 14);
      lo = $urandom_range(1, 90);
      bus.Continue = 1'b1;
      for (int i = 0; i < hi; i++) begin rand_inputs(); tick(1); end
      bus.Continue = 1'b0;
      for (int i = 0; i < lo; i++) begin rand_inputs(); tick(1); end
    end
    tick(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
